// File: rtl/mul_div_unit.sv
// mul_div_unit -- iterative HI/LO multiply/divide unit for the execute stage.
//
// Owns the architectural HI/LO registers. Multiplies finish after MUL_CYCLES
// cycles. Divides take 32 restoring radix-2 iterations plus one sign-fix
// cycle. MTHI/MTLO write HI/LO directly from IDLE and never raise busy.
//
// Ports:
//   clk    in  1   rising-edge clock
//   reset  in  1   synchronous active-high reset, clears all state
//   start  in  1   operation request, only honoured when idle
//   op     in  3   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   srca   in  32  rs: multiplicand / dividend / MTHI-MTLO source
//   srcb   in  32  rt: multiplier / divisor
//   busy   out 1   registered, high while a multiply or divide is in flight
//   done   out 1   registered, one-cycle pulse when a result lands in HI/LO
//   hi     out 32  HI register
//   lo     out 32  LO register
module mul_div_unit #(
  parameter int MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_a;       // latched srca (multiplicand, or original dividend)
  logic [31:0] r_b;       // latched multiplier
  logic        r_signed;  // multiply is signed
  logic [31:0] r_quo;     // dividend magnitude, shifted out as quotient shifts in
  logic [31:0] r_rem;     // partial remainder
  logic [31:0] r_dvs;     // divisor magnitude
  logic        r_qneg;    // quotient must be negated in FIX
  logic        r_rneg;    // remainder must be negated in FIX
  logic        r_dz;      // divide by zero

  // Multiply: extend to 64 bits by signedness; the low 64 bits of the
  // product are then correct for both MULT and MULTU.
  logic [63:0] w_mul_a, w_mul_b, w_prod;
  assign w_mul_a = r_signed ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
  assign w_mul_b = r_signed ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
  assign w_prod  = w_mul_a * w_mul_b;

  // Divide operand conditioning at accept.
  logic        w_div_sgn;
  logic [31:0] w_amag, w_bmag;
  assign w_div_sgn = (op == OP_DIV);
  assign w_amag    = (w_div_sgn && srca[31]) ? (32'd0 - srca) : srca;
  assign w_bmag    = (w_div_sgn && srcb[31]) ? (32'd0 - srcb) : srcb;

  // One restoring step: shift the next dividend bit into the remainder and
  // try to subtract. The shifted remainder can reach 33 bits for unsigned
  // divisors near 2^32, so the trial subtract is carried at 34 bits and
  // bit 33 is the borrow.
  logic [32:0] w_shift;
  logic [33:0] w_diff;
  logic        w_ge;
  assign w_shift = {r_rem, r_quo[31]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, r_dvs};
  assign w_ge    = ~w_diff[33];

  logic [31:0] w_qfix, w_rfix;
  assign w_qfix = r_qneg ? (32'd0 - r_quo) : r_quo;
  assign w_rfix = r_rneg ? (32'd0 - r_rem) : r_rem;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_dz     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                r_a      <= srca;
                r_b      <= srcb;
                r_signed <= (op == OP_MULT);
                r_cnt    <= 6'(MUL_CYCLES - 1);
                busy     <= 1'b1;
                r_state  <= S_MUL;
              end
              OP_DIV, OP_DIVU: begin
                r_a     <= srca;
                r_quo   <= w_amag;
                r_dvs   <= w_bmag;
                r_rem   <= '0;
                r_qneg  <= w_div_sgn && (srca[31] ^ srcb[31]);
                r_rneg  <= w_div_sgn && srca[31];
                r_dz    <= (srcb == 32'd0);
                r_cnt   <= 6'd31;
                busy    <= 1'b1;
                r_state <= S_DIV;
              end
              OP_MTHI: hi <= srca;
              OP_MTLO: lo <= srca;
              default: ;  // reserved ops are ignored
            endcase
          end
        end
        S_MUL: begin
          if (r_cnt == 6'd0) begin
            {hi, lo} <= w_prod;
            busy     <= 1'b0;
            done     <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 6'd1;
          end
        end
        S_DIV: begin
          r_rem <= w_ge ? w_diff[31:0] : w_shift[31:0];
          r_quo <= {r_quo[30:0], w_ge};
          if (r_cnt == 6'd0) r_state <= S_FIX;
          else               r_cnt   <= r_cnt - 6'd1;
        end
        S_FIX: begin
          // Divide by zero overrides the iteration result with fixed values.
          if (r_dz) begin
            lo <= 32'hFFFF_FFFF;
            hi <= r_a;
          end else begin
            lo <= w_qfix;
            hi <= w_rfix;
          end
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] srca, srcb;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  mul_div_unit #(.MUL_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .srca(srca), .srcb(srcb), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          lat;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Called at a negedge (cycle T). Issues the op, checks busy/done/hold for
  // L cycles, and returns at the negedge of cycle T+L+1 with results checked.
  task automatic run(input vec_t v, input string name);
    logic [31:0] phi, plo;
    int busy_ok, hold_ok;
    phi = hi; plo = lo;
    start = 1'b1; op = v.op; srca = v.a; srcb = v.b;
    chk({name, " busy_in_accept"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    busy_ok = 1; hold_ok = 1;
    for (int k = 1; k <= v.lat; k++) begin
      if (busy !== 1'b1 || done !== 1'b0) busy_ok = 0;
      if (hi !== phi || lo !== plo) hold_ok = 0;
      @(negedge clk);
    end
    chk({name, " busy_window"}, busy_ok, 1);
    chk({name, " hilo_hold"}, hold_ok, 1);
    chk({name, " busy_end"}, {31'd0, busy}, 32'd0);
    chk({name, " done"}, {31'd0, done}, 32'd1);
    chk({name, " hi"}, hi, v.ehi);
    chk({name, " lo"}, lo, v.elo);
  endtask

  initial begin
    vec_t v;
    logic [31:0] plo, phi;
    vt[0] = '{3'b000, 32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1, 4};
    vt[1] = '{3'b001, 32'hFFFF_FFFD, 32'd5,          32'h0000_0004, 32'hFFFF_FFF1, 4};
    vt[2] = '{3'b010, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vt[3] = '{3'b011, 32'd100,       32'd7,          32'd2,         32'd14,        33};
    vt[4] = '{3'b011, 32'h0000_1234, 32'd0,          32'h0000_1234, 32'hFFFF_FFFF, 33};
    vt[5] = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000, 33};
    vt[6] = '{3'b010, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD, 33};
    vt[7] = '{3'b000, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'd0,         4};
    vt[8] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'd1,         4};
    vt[9] = '{3'b010, 32'hFFFF_FFF0, 32'd0,          32'hFFFF_FFF0, 32'hFFFF_FFFF, 33};

    reset = 1'b1; start = 1'b0; op = 3'b000; srca = '0; srcb = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);

    // Vectors run back-to-back: each starts in the previous one's done cycle.
    for (int i = 0; i < 10; i++) run(vt[i], $sformatf("vec%0d", i));
    @(negedge clk);
    chk("done_pulse_one_cycle", {31'd0, done}, 32'd0);

    // MTHI while idle.
    start = 1'b1; op = 3'b100; srca = 32'h55;
    @(negedge clk);
    start = 1'b0;
    chk("mthi hi", hi, 32'h55);
    chk("mthi done", {31'd0, done}, 32'd0);
    chk("mthi busy", {31'd0, busy}, 32'd0);

    // MTLO while busy is ignored.
    plo = lo;
    start = 1'b1; op = 3'b001; srca = 32'd6; srcb = 32'd7;
    @(negedge clk);
    op = 3'b101; srca = 32'hAAAA;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_busy lo_kept", lo, plo);
    repeat (3) @(negedge clk);
    chk("mtlo_busy result lo", lo, 32'd42);
    chk("mtlo_busy result hi", hi, 32'd0);

    // Reserved op 111: no state change.
    phi = hi; plo = lo;
    start = 1'b1; op = 3'b111; srca = 32'hDEAD_BEEF; srcb = 32'd3;
    @(negedge clk);
    start = 1'b0;
    chk("op111 busy", {31'd0, busy}, 32'd0);
    chk("op111 done", {31'd0, done}, 32'd0);
    chk("op111 hi", hi, phi);
    chk("op111 lo", lo, plo);
    @(negedge clk);
    chk("op111 busy later", {31'd0, busy}, 32'd0);

    // Reset at cycle 10 of a DIV.
    v = '{3'b011, 32'd1000, 32'd3, 32'd1, 32'd333, 33};
    start = 1'b1; op = v.op; srca = v.a; srcb = v.b;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("div_mid busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    run('{3'b001, 32'd3, 32'd4, 32'd0, 32'd12, 4}, "post_abort");

    // Reset and start together: reset wins.
    reset = 1'b1; start = 1'b1; op = 3'b100; srca = 32'h99;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("rst_start hi", hi, 32'd0);
    chk("rst_start lo", lo, 32'd0);
    chk("rst_start busy", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
